// File: rtl/dcf77_tx.sv
// DCF77 minute-frame transmitter: latches BCD time at each minute mark
// and emits 100/200 ms amplitude-reduction pulses, one bit per second.
module dcf77_tx #(
    parameter int TICKS_PER_SEC = 100,
    parameter int T0_TICKS      = 10,
    parameter int T1_TICKS      = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    input  logic       enable,
    input  logic [7:0] year,
    input  logic [4:0] month,
    input  logic [5:0] day,
    input  logic [2:0] day_of_week,
    input  logic [5:0] hour,
    input  logic [6:0] minute,
    input  logic       cest,
    output logic       tx,
    output logic       frame_start,
    output logic [5:0] second
);

    localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [TW-1:0] L_TMAX = TW'(TICKS_PER_SEC - 1);
    localparam logic [TW-1:0] L_T0   = TW'(T0_TICKS);
    localparam logic [TW-1:0] L_T1   = TW'(T1_TICKS);
    localparam logic [5:0]    L_GAP  = 6'd59;

    logic [TW-1:0] r_tick;
    logic [5:0]    r_sec;
    logic [58:0]   r_frame;
    logic          r_tx;
    logic          r_fs;

    logic [TW-1:0] w_tick_nxt;
    logic [5:0]    w_sec_nxt;
    logic [58:0]   w_frame_nxt;
    logic [58:0]   w_frame_new;
    logic [59:0]   w_frame_ext;
    logic          w_fs_nxt;
    logic          w_bit;
    logic [TW-1:0] w_width;
    logic          w_tx_nxt;

    // Bit layout matches the receiver's data_hold[58:0]
    always_comb begin
        w_frame_new        = '0;
        w_frame_new[17]    = cest;
        w_frame_new[18]    = ~cest;
        w_frame_new[20]    = 1'b1;
        w_frame_new[27:21] = minute;
        w_frame_new[28]    = ^minute;
        w_frame_new[34:29] = hour;
        w_frame_new[35]    = ^hour;
        w_frame_new[41:36] = day;
        w_frame_new[44:42] = day_of_week;
        w_frame_new[49:45] = month;
        w_frame_new[57:50] = year;
        w_frame_new[58]    = ^{year, month, day_of_week, day};
    end

    always_comb begin
        w_tick_nxt  = r_tick;
        w_sec_nxt   = r_sec;
        w_frame_nxt = r_frame;
        w_fs_nxt    = 1'b0;
        if (!enable) begin
            w_tick_nxt = '0;
            w_sec_nxt  = L_GAP;
        end else if (clk_en) begin
            if (r_tick == L_TMAX) begin
                w_tick_nxt = '0;
                if (r_sec == L_GAP) begin
                    w_sec_nxt   = 6'd0;
                    w_frame_nxt = w_frame_new;
                    w_fs_nxt    = 1'b1;
                end else begin
                    w_sec_nxt = r_sec + 6'd1;
                end
            end else begin
                w_tick_nxt = r_tick + 1'b1;
            end
        end
    end

    // tx is computed from next-state so the flop tracks the live sec/tick
    always_comb begin
        w_frame_ext = {1'b0, w_frame_nxt};
        w_bit       = w_frame_ext[w_sec_nxt];
        w_width     = w_bit ? L_T1 : L_T0;
        w_tx_nxt    = (w_sec_nxt != L_GAP) && (w_tick_nxt < w_width);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tick  <= '0;
            r_sec   <= L_GAP;
            r_frame <= '0;
            r_tx    <= 1'b0;
            r_fs    <= 1'b0;
        end else begin
            r_tick  <= w_tick_nxt;
            r_sec   <= w_sec_nxt;
            r_frame <= w_frame_nxt;
            r_tx    <= w_tx_nxt;
            r_fs    <= w_fs_nxt;
        end
    end

    assign tx          = r_tx;
    assign frame_start = r_fs;
    assign second      = r_sec;

endmodule

// File: tb/tb_dcf77_tx.sv
// Randomised bench for dcf77_tx: time-based reference model of the
// pulse train, pulse-width capture and decode of each transmitted frame.
module tb_dcf77_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       clk_en;
    logic       enable;
    logic [7:0] year;
    logic [4:0] month;
    logic [5:0] day;
    logic [2:0] dow;
    logic [5:0] hour;
    logic [6:0] minute;
    logic       cest;
    logic       tx;
    logic       frame_start;
    logic [5:0] second;

    always #5 clk = ~clk;

    dcf77_tx #(
        .TICKS_PER_SEC(100),
        .T0_TICKS(10),
        .T1_TICKS(20)
    ) dut (
        .clk(clk),
        .rst(rst),
        .clk_en(clk_en),
        .enable(enable),
        .year(year),
        .month(month),
        .day(day),
        .day_of_week(dow),
        .hour(hour),
        .minute(minute),
        .cest(cest),
        .tx(tx),
        .frame_start(frame_start),
        .second(second)
    );

    int          checks = 0;
    int          errors = 0;
    int          t = 0;
    logic [58:0] m_frame = '0;
    int          wid[60];
    int          last_rise = -1;
    logic        prev_tx = 1'b0;

    function automatic logic [58:0] ref_frame(
        input logic [7:0] yr, input logic [4:0] mo, input logic [5:0] dy,
        input logic [2:0] dw, input logic [5:0] hr, input logic [6:0] mi,
        input logic c);
        logic [58:0] f;
        int ones;
        f = '0;
        f[17] = c;
        f[18] = !c;
        f[20] = 1'b1;
        for (int i = 0; i < 7; i++) f[21+i] = mi[i];
        f[28] = ($countones(mi) % 2) == 1;
        for (int i = 0; i < 6; i++) f[29+i] = hr[i];
        f[35] = ($countones(hr) % 2) == 1;
        for (int i = 0; i < 6; i++) f[36+i] = dy[i];
        for (int i = 0; i < 3; i++) f[42+i] = dw[i];
        for (int i = 0; i < 5; i++) f[45+i] = mo[i];
        for (int i = 0; i < 8; i++) f[50+i] = yr[i];
        ones = $countones(dy) + $countones(dw) + $countones(mo) + $countones(yr);
        f[58] = (ones % 2) == 1;
        return f;
    endfunction

    // A bit is read as 1 when its pulse lasted at least 150 ms
    function automatic int field(input int lo, input int n);
        int v;
        v = 0;
        for (int i = 0; i < n; i++)
            if (wid[lo+i] >= 15) v = v | (1 << i);
        return v;
    endfunction

    task automatic tick_once();
        int s;
        int k;
        int g;
        logic fs_e;
        logic tx_e;
        @(negedge clk);
        clk_en = 1'b1;
        @(posedge clk);
        #1;
        clk_en = 1'b0;
        fs_e = 1'b0;
        if (enable) begin
            t++;
            if (t % 6000 == 100) begin
                m_frame = ref_frame(year, month, day, dow, hour, minute, cest);
                fs_e = 1'b1;
            end
        end
        s = (59 + t / 100) % 60;
        k = t % 100;
        tx_e = 1'b0;
        if (s != 59) tx_e = (k < (m_frame[s] ? 20 : 10));
        checks += 3;
        if (second !== 6'(s)) begin
            errors++;
            $display("FAIL second t=%0d: got %0d want %0d", t, second, s);
        end
        if (tx !== tx_e) begin
            errors++;
            $display("FAIL tx t=%0d sec=%0d tick=%0d: got %b want %b", t, s, k, tx, tx_e);
        end
        if (frame_start !== fs_e) begin
            errors++;
            $display("FAIL frame_start t=%0d: got %b want %b", t, frame_start, fs_e);
        end
        if (tx === 1'b1) wid[s]++;
        if (tx === 1'b1 && !prev_tx) begin
            if (last_rise >= 0) begin
                g = (s == 0) ? 200 : 100;
                checks++;
                if (t - last_rise != g) begin
                    errors++;
                    $display("FAIL rise_spacing sec=%0d: got %0d want %0d", s, t - last_rise, g);
                end
            end
            last_rise = t;
        end
        prev_tx = tx;
        repeat ($urandom_range(0, 1)) begin
            @(posedge clk);
            #1;
            checks++;
            if (frame_start !== 1'b0) begin
                errors++;
                $display("FAIL frame_start_idle t=%0d: got %b want 0", t, frame_start);
            end
        end
    endtask

    task automatic run_minute(input int chg_sec, input logic [6:0] new_min,
                              input int exp_min);
        int e;
        for (int i = 0; i < 60; i++) wid[i] = 0;
        repeat (6000) begin
            tick_once();
            if (chg_sec >= 0 && t % 6000 == 100 + chg_sec * 100) minute = new_min;
        end
        for (int n = 0; n < 60; n++) begin
            e = (n == 59) ? 0 : (m_frame[n] ? 20 : 10);
            checks++;
            if (wid[n] != e) begin
                errors++;
                $display("FAIL pulse_width bit%0d: got %0d want %0d", n, wid[n], e);
            end
        end
        checks++;
        if (field(21, 7) != exp_min) begin
            errors++;
            $display("FAIL decoded_minute: got %h want %h", field(21, 7), exp_min);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        enable = 1'b0;
        clk_en = 1'b0;
        #23;
        checks += 3;
        if (tx !== 1'b0) begin
            errors++;
            $display("FAIL reset_tx: got %b want 0", tx);
        end
        if (second !== 6'd59) begin
            errors++;
            $display("FAIL reset_second: got %0d want 59", second);
        end
        if (frame_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_frame_start: got %b want 0", frame_start);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (500) tick_once();
    endtask

    task automatic test_known_frame();
        year = 8'h24;
        month = 5'h06;
        day = 6'h15;
        dow = 3'd6;
        hour = 6'h13;
        minute = 7'h45;
        cest = 1'b1;
        @(negedge clk);
        enable = 1'b1;
        t = 0;
        run_minute(-1, 7'h00, 'h45);
        checks += 6;
        if (field(29, 6) != 'h13) begin
            errors++;
            $display("FAIL decoded_hour: got %h want 13", field(29, 6));
        end
        if (field(36, 6) != 'h15) begin
            errors++;
            $display("FAIL decoded_day: got %h want 15", field(36, 6));
        end
        if (field(42, 3) != 6) begin
            errors++;
            $display("FAIL decoded_dow: got %0d want 6", field(42, 3));
        end
        if (field(45, 5) != 'h06) begin
            errors++;
            $display("FAIL decoded_month: got %h want 06", field(45, 5));
        end
        if (field(50, 8) != 'h24) begin
            errors++;
            $display("FAIL decoded_year: got %h want 24", field(50, 8));
        end
        if (wid[17] != 20 || wid[18] != 10 || wid[20] != 20) begin
            errors++;
            $display("FAIL cest_bits: got %0d/%0d/%0d want 20/10/20", wid[17], wid[18], wid[20]);
        end
        run_minute(30, 7'h46, 'h45);
        run_minute(-1, 7'h00, 'h46);
    endtask

    task automatic test_random();
        int m0;
        for (int r = 0; r < 2; r++) begin
            year = 8'($urandom);
            month = 5'($urandom);
            day = 6'($urandom);
            dow = 3'($urandom);
            hour = 6'($urandom);
            minute = 7'($urandom);
            cest = 1'($urandom);
            m0 = int'(minute);
            run_minute($urandom_range(5, 55), 7'($urandom), m0);
        end
    endtask

    task automatic test_enable_drop();
        int n;
        n = 0;
        while (!(((59 + t / 100) % 60) == 25 && t % 100 == 5) && n < 7000) begin
            tick_once();
            n++;
        end
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk);
        #1;
        checks += 3;
        if (tx !== 1'b0) begin
            errors++;
            $display("FAIL drop_tx: got %b want 0", tx);
        end
        if (second !== 6'd59) begin
            errors++;
            $display("FAIL drop_second: got %0d want 59", second);
        end
        if (frame_start !== 1'b0) begin
            errors++;
            $display("FAIL drop_frame_start: got %b want 0", frame_start);
        end
        t = 0;
        prev_tx = 1'b0;
        last_rise = -1;
        repeat (50) tick_once();
        @(negedge clk);
        enable = 1'b1;
        n = 0;
        while (tx !== 1'b1 && n < 200) begin
            tick_once();
            n++;
        end
        checks++;
        if (tx !== 1'b1 || t != 100) begin
            errors++;
            $display("FAIL reenable_first_pulse: got tick %0d want 100", t);
        end
    endtask

    task automatic test_async_reset();
        #3;
        rst = 1'b0;
        #1;
        checks += 2;
        if (tx !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_tx: got %b want 0", tx);
        end
        if (second !== 6'd59) begin
            errors++;
            $display("FAIL async_reset_second: got %0d want 59", second);
        end
        @(negedge clk);
        rst = 1'b1;
        t = 0;
        m_frame = '0;
        prev_tx = 1'b0;
        last_rise = -1;
        minute = 7'h12;
        repeat (250) tick_once();
    endtask

    initial begin
        year = '0;
        month = '0;
        day = '0;
        dow = '0;
        hour = '0;
        minute = '0;
        cest = 1'b0;
        test_reset();
        test_known_frame();
        test_random();
        test_enable_drop();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
